// File: rtl/cas_upload_reader.sv
// Tape (CAS) buffer upload reader: walks the tape buffer through a req/ack read port and
// keeps the next byte prefetched on ioctl_din_o for the host's next ioctl_rd_i strobe.
module cas_upload_reader #(
    parameter int unsigned     AW           = 16,
    parameter logic [AW-1:0]   BASE_ADDR    = '0,
    parameter logic [7:0]      UPLOAD_INDEX = 8'd2,
    parameter logic [7:0]      PAD_BYTE     = 8'h00
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          ioctl_upload_i,
    input  logic [7:0]    ioctl_index_i,
    input  logic          ioctl_rd_i,
    output logic [7:0]    ioctl_din_o,
    input  logic [15:0]   len_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [7:0]    mem_data_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_READY,
        ST_ABORT
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] off_reg, off_next;
    logic [15:0] len_reg, len_next;
    logic [7:0]  din_reg, din_next;
    logic        ready_reg, ready_next;
    logic        done_reg, done_next;
    logic        overrun_reg, overrun_next;
    logic        pending_reg, pending_next;

    logic          active;
    logic          mem_req;
    logic          do_adv;
    logic [16:0]   off_inc;
    logic [15:0]   off_sat;
    logic          more_bytes;
    logic          at_end;
    logic [AW-1:0] addr_sum;

    assign active     = ioctl_upload_i && (ioctl_index_i == UPLOAD_INDEX);

    // 17-bit increment so offset 16'hFFFF neither wraps nor fakes a match against len
    assign off_inc    = {1'b0, off_reg} + 17'd1;
    assign off_sat    = off_inc[16] ? 16'hFFFF : off_inc[15:0];
    assign more_bytes = off_inc < {1'b0, len_reg};
    assign at_end     = off_inc == {1'b0, len_reg};

    assign addr_sum   = BASE_ADDR + AW'(off_reg);

    always_comb begin
        state_next   = state_reg;
        off_next     = off_reg;
        len_next     = len_reg;
        din_next     = din_reg;
        ready_next   = ready_reg;
        done_next    = 1'b0;
        overrun_next = overrun_reg;
        pending_next = pending_reg;
        mem_req      = 1'b0;
        do_adv       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready_next = 1'b0;
                if (active) begin
                    len_next     = len_i;
                    off_next     = 16'd0;
                    overrun_next = 1'b0;
                    pending_next = 1'b0;
                    if (len_i == 16'd0) begin
                        din_next   = PAD_BYTE;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                        state_next = ST_READY;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                mem_req    = 1'b1;
                ready_next = 1'b0;
                if (!active) begin
                    // An outstanding request must still see its ack before we go idle
                    pending_next = 1'b0;
                    state_next   = mem_ack_i ? ST_IDLE : ST_ABORT;
                end else if (mem_ack_i) begin
                    din_next     = mem_data_i;
                    pending_next = 1'b0;
                    if (pending_reg || ioctl_rd_i) begin
                        overrun_next = overrun_reg | (pending_reg & ioctl_rd_i);
                        do_adv       = 1'b1;
                    end else begin
                        ready_next = 1'b1;
                        state_next = ST_READY;
                    end
                end else if (ioctl_rd_i) begin
                    if (pending_reg) begin
                        overrun_next = 1'b1;
                    end else begin
                        pending_next = 1'b1;
                    end
                end
            end

            ST_READY: begin
                if (!active) begin
                    ready_next = 1'b0;
                    state_next = ST_IDLE;
                end else if (ioctl_rd_i) begin
                    do_adv = 1'b1;
                end
            end

            ST_ABORT: begin
                mem_req    = 1'b1;
                ready_next = 1'b0;
                if (mem_ack_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Step to the next offset: fetch while inside the tape, pad once past its end
        if (do_adv) begin
            off_next = off_sat;
            if (more_bytes) begin
                ready_next = 1'b0;
                state_next = ST_FETCH;
            end else begin
                din_next   = PAD_BYTE;
                ready_next = 1'b1;
                done_next  = at_end;
                state_next = ST_READY;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg   <= ST_IDLE;
            off_reg     <= 16'd0;
            len_reg     <= 16'd0;
            din_reg     <= 8'h00;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            off_reg     <= off_next;
            len_reg     <= len_next;
            din_reg     <= din_next;
            ready_reg   <= ready_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
            pending_reg <= pending_next;
        end
    end

    assign mem_req_o   = mem_req;
    assign mem_addr_o  = mem_req ? addr_sum : '0;
    assign ioctl_din_o = din_reg;
    assign ready_o     = ready_reg;
    assign done_o      = done_reg;
    assign overrun_o   = overrun_reg;

endmodule

// File: tb/tb_cas_upload_reader.sv
// Bench for cas_upload_reader: a latency-programmable buffer responder plus a scoreboard of
// expected ioctl_din_o bytes and buffer addresses, one task per scenario.
module tb_cas_upload_reader;

    localparam logic [7:0] PAD = 8'h00;

    logic        clk_i;
    logic        reset_n_i;
    logic        ioctl_upload_i;
    logic [7:0]  ioctl_index_i;
    logic        ioctl_rd_i;
    logic [7:0]  ioctl_din_o;
    logic [15:0] len_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        ready_o;
    logic        done_o;
    logic        overrun_o;

    int checks    = 0;
    int passes    = 0;
    int lat       = 1;
    int ack_count = 0;
    int done_cnt  = 0;

    logic [15:0] addr_hist [0:255];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_addr[$];

    cas_upload_reader #(
        .AW(16),
        .BASE_ADDR(16'hFFFE),
        .UPLOAD_INDEX(8'd2),
        .PAD_BYTE(PAD)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .ioctl_upload_i(ioctl_upload_i),
        .ioctl_index_i(ioctl_index_i),
        .ioctl_rd_i(ioctl_rd_i),
        .ioctl_din_o(ioctl_din_o),
        .len_i(len_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i),
        .ready_o(ready_o),
        .done_o(done_o),
        .overrun_o(overrun_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Buffer contents: tape bytes 0..3 live at FFFE, FFFF, 0000, 0001
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'hA1;
            16'hFFFF: return 8'hB2;
            16'h0000: return 8'hC3;
            16'h0001: return 8'hD4;
            default:  return 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] tape_byte(input int i);
        case (i)
            0:       return 8'hA1;
            1:       return 8'hB2;
            2:       return 8'hC3;
            default: return 8'hD4;
        endcase
    endfunction

    initial begin : responder
        int wait_cnt;
        wait_cnt   = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o === 1'b1) begin
                if (wait_cnt >= lat - 1) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_byte(mem_addr_o);
                    addr_hist[ack_count % 256] = mem_addr_o;
                    ack_count++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe();
        ioctl_rd_i = 1'b1;
        @(negedge clk_i);
        ioctl_rd_i = 1'b0;
    endtask

    task automatic start_session(input logic [15:0] len);
        ioctl_index_i  = 8'd2;
        len_i          = len;
        ioctl_upload_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic end_session();
        ioctl_upload_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({ready_o, done_o, overrun_o, mem_req_o, ioctl_din_o, mem_addr_o} !== 28'd0)
            $display("FAIL reset_outputs: rdy=%b done=%b ovr=%b req=%b din=%h addr=%h want all 0",
                     ready_o, done_o, overrun_o, mem_req_o, ioctl_din_o, mem_addr_o);
        else passes++;
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stream();
        bit ok;
        logic [7:0] e;
        int d0, a0;
        lat = 2;
        d0  = done_cnt;
        a0  = ack_count;
        start_session(16'd3);
        len_i = 16'd100;
        checks++;
        if ({ready_o, mem_req_o} !== 2'b01)
            $display("FAIL stream_fetch: ready/req=%b%b want 01", ready_o, mem_req_o);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(tape_byte(i));
            if (i > 0) begin
                strobe();
                checks++;
                if ({ready_o, mem_req_o} !== 2'b01)
                    $display("FAIL stream_refetch%0d: ready/req=%b%b want 01", i, ready_o, mem_req_o);
                else passes++;
            end
            wait_ready(20, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || ioctl_din_o !== e)
                $display("FAIL stream_din%0d: ready=%b din=%h want %h", i, ready_o, ioctl_din_o, e);
            else passes++;
            $display("read off=%0d din=%h", i, ioctl_din_o);
        end
        checks++;
        if (done_cnt !== d0)
            $display("FAIL stream_early_done: done pulses=%0d want 0", done_cnt - d0);
        else passes++;
        exp_q.push_back(PAD);
        strobe();
        e = exp_q.pop_front();
        checks++;
        if ({done_o, ready_o, mem_req_o} !== 3'b110 || ioctl_din_o !== e)
            $display("FAIL stream_end: done/rdy/req=%b%b%b din=%h want 110 din=%h",
                     done_o, ready_o, mem_req_o, ioctl_din_o, e);
        else passes++;
        $display("read off=3 din=%h done=%b", ioctl_din_o, done_o);
        exp_q.push_back(PAD);
        strobe();
        e = exp_q.pop_front();
        checks++;
        if (mem_req_o !== 1'b0 || ioctl_din_o !== e)
            $display("FAIL stream_past_end: req=%b din=%h want req=0 din=%h", mem_req_o, ioctl_din_o, e);
        else passes++;
        $display("read off=4 din=%h", ioctl_din_o);
        @(negedge clk_i);
        checks++;
        if (done_cnt - d0 !== 1 || ack_count - a0 !== 3)
            $display("FAIL stream_counts: done pulses=%0d acks=%0d want 1 and 3",
                     done_cnt - d0, ack_count - a0);
        else passes++;
        len_i = 16'd0;
        end_session();
    endtask

    task automatic test_addr_wrap();
        bit ok;
        logic [7:0]  e;
        logic [15:0] ea;
        int a0;
        lat = 1;
        a0  = ack_count;
        exp_addr.push_back(16'hFFFE);
        exp_addr.push_back(16'hFFFF);
        exp_addr.push_back(16'h0000);
        exp_addr.push_back(16'h0001);
        start_session(16'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(tape_byte(i));
            if (i > 0) strobe();
            wait_ready(20, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || ioctl_din_o !== e)
                $display("FAIL wrap_din%0d: ready=%b din=%h want %h", i, ready_o, ioctl_din_o, e);
            else passes++;
            $display("read off=%0d din=%h", i, ioctl_din_o);
        end
        checks++;
        if (ack_count - a0 !== 4)
            $display("FAIL wrap_acks: acks=%0d want 4", ack_count - a0);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            ea = exp_addr.pop_front();
            checks++;
            if (addr_hist[(a0 + i) % 256] !== ea)
                $display("FAIL wrap_addr%0d: addr=%h want %h", i, addr_hist[(a0 + i) % 256], ea);
            else passes++;
        end
        end_session();
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] e;
        int a0;
        lat = 4;
        start_session(16'd4);
        wait_ready(20, ok);
        checks++;
        if (!ok || ioctl_din_o !== 8'hA1)
            $display("FAIL ovr_first: ready=%b din=%h want A1", ready_o, ioctl_din_o);
        else passes++;
        a0 = ack_count;
        strobe();
        exp_q.push_back(8'hC3);
        strobe();
        checks++;
        if (overrun_o !== 1'b0)
            $display("FAIL ovr_pending: overrun=%b want 0", overrun_o);
        else passes++;
        strobe();
        checks++;
        if (overrun_o !== 1'b1)
            $display("FAIL ovr_set: overrun=%b want 1", overrun_o);
        else passes++;
        wait_ready(40, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || ioctl_din_o !== e || overrun_o !== 1'b1)
            $display("FAIL ovr_served: ready=%b din=%h ovr=%b want din %h ovr 1",
                     ready_o, ioctl_din_o, overrun_o, e);
        else passes++;
        $display("read off=2 din=%h overrun=%b", ioctl_din_o, overrun_o);
        checks++;
        if (ack_count - a0 !== 2 || addr_hist[(a0 + 1) % 256] !== 16'h0000)
            $display("FAIL ovr_fetches: acks=%0d last addr=%h want 2 and 0000",
                     ack_count - a0, addr_hist[(a0 + 1) % 256]);
        else passes++;
        end_session();
        start_session(16'd1);
        checks++;
        if (overrun_o !== 1'b0)
            $display("FAIL ovr_clear: overrun=%b want 0", overrun_o);
        else passes++;
        wait_ready(20, ok);
        strobe();
        checks++;
        if (ioctl_din_o !== PAD || ready_o !== 1'b1)
            $display("FAIL ovr_short_end: din=%h ready=%b want %h 1", ioctl_din_o, ready_o, PAD);
        else passes++;
        end_session();
    endtask

    task automatic test_abort();
        bit ok, held, got;
        logic [7:0] e;
        int a0;
        lat  = 7;
        a0   = ack_count;
        held = 1'b1;
        got  = 1'b0;
        start_session(16'd4);
        ioctl_upload_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (ack_count != a0) begin
                got = 1'b1;
                break;
            end
            if (mem_req_o !== 1'b1 || mem_addr_o !== 16'hFFFE || ready_o !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!got || !held)
            $display("FAIL abort_hold: ack seen=%b req held=%b want 1 1", got, held);
        else passes++;
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, ready_o} !== 2'b00 || ioctl_din_o !== PAD)
            $display("FAIL abort_idle: req=%b ready=%b din=%h want 0 0 %h",
                     mem_req_o, ready_o, ioctl_din_o, PAD);
        else passes++;
        lat = 1;
        a0  = ack_count;
        exp_q.push_back(8'hA1);
        start_session(16'd2);
        wait_ready(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || ioctl_din_o !== e || addr_hist[a0 % 256] !== 16'hFFFE)
            $display("FAIL abort_restart: din=%h addr=%h want %h FFFE",
                     ioctl_din_o, addr_hist[a0 % 256], e);
        else passes++;
        $display("read off=0 din=%h after abort", ioctl_din_o);
        end_session();
    endtask

    task automatic test_wrong_index();
        bit bad;
        int a0;
        a0  = ack_count;
        bad = 1'b0;
        ioctl_index_i  = 8'd3;
        len_i          = 16'd4;
        ioctl_upload_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ioctl_rd_i = (i == 2);
            @(negedge clk_i);
            if (mem_req_o !== 1'b0 || ready_o !== 1'b0) bad = 1'b1;
        end
        ioctl_rd_i = 1'b0;
        checks++;
        if (bad || ack_count != a0)
            $display("FAIL index_ignored: activity=%b acks=%0d want 0 0", bad, ack_count - a0);
        else passes++;
        ioctl_upload_i = 1'b0;
        ioctl_index_i  = 8'd2;
        @(negedge clk_i);
    endtask

    task automatic test_len_zero();
        logic [7:0] e;
        int d0, a0;
        d0 = done_cnt;
        a0 = ack_count;
        exp_q.push_back(PAD);
        start_session(16'd0);
        e = exp_q.pop_front();
        checks++;
        if ({ready_o, done_o, mem_req_o} !== 3'b110 || ioctl_din_o !== e)
            $display("FAIL len0_start: rdy/done/req=%b%b%b din=%h want 110 %h",
                     ready_o, done_o, mem_req_o, ioctl_din_o, e);
        else passes++;
        $display("read off=0 din=%h len=0", ioctl_din_o);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0)
            $display("FAIL len0_pulse: done=%b want 0", done_o);
        else passes++;
        exp_q.push_back(PAD);
        strobe();
        e = exp_q.pop_front();
        checks++;
        if ({ready_o, done_o} !== 2'b10 || ioctl_din_o !== e)
            $display("FAIL len0_strobe: rdy/done=%b%b din=%h want 10 %h", ready_o, done_o, ioctl_din_o, e);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (done_cnt - d0 !== 1 || ack_count != a0)
            $display("FAIL len0_counts: done pulses=%0d acks=%0d want 1 0", done_cnt - d0, ack_count - a0);
        else passes++;
        end_session();
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [7:0] e;
        lat = 12;
        start_session(16'd4);
        strobe();
        strobe();
        checks++;
        if (overrun_o !== 1'b1 || mem_req_o !== 1'b1)
            $display("FAIL rst_setup: overrun=%b req=%b want 1 1", overrun_o, mem_req_o);
        else passes++;
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({ready_o, done_o, overrun_o, mem_req_o, ioctl_din_o, mem_addr_o} !== 28'd0)
            $display("FAIL rst_async: rdy=%b done=%b ovr=%b req=%b din=%h addr=%h want all 0",
                     ready_o, done_o, overrun_o, mem_req_o, ioctl_din_o, mem_addr_o);
        else passes++;
        ioctl_upload_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, ready_o} !== 2'b00)
            $display("FAIL rst_idle: req=%b ready=%b want 0 0", mem_req_o, ready_o);
        else passes++;
        lat = 1;
        exp_q.push_back(8'hA1);
        start_session(16'd1);
        wait_ready(20, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || ioctl_din_o !== e)
            $display("FAIL rst_restart: ready=%b din=%h want %h", ready_o, ioctl_din_o, e);
        else passes++;
        $display("read off=0 din=%h after reset", ioctl_din_o);
        end_session();
    endtask

    initial begin
        reset_n_i      = 1'b0;
        ioctl_upload_i = 1'b0;
        ioctl_index_i  = 8'd2;
        ioctl_rd_i     = 1'b0;
        len_i          = 16'd0;
        test_reset();
        test_stream();
        test_addr_wrap();
        test_overrun();
        test_abort();
        test_wrong_index();
        test_len_zero();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
